// File: rtl/rip_axi_pkg.sv
// Shared constants, types and helpers for the RIP AXI interconnect.
package rip_axi_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // Width of the master index field; never narrower than one bit.
    function automatic int unsigned midx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

endpackage

// File: rtl/rip_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
module rip_rr_arbiter #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             granted
);

    logic [IDX_W-1:0] last_q;
    logic             found;
    int               cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int i = 1; i <= int'(N); i++) begin
            cand = (int'(last_q) + i) % int'(N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
        granted = en && found;
        grant   = '0;
        if (granted) grant[idx] = 1'b1;
    end

    // Reset pointer at the last master so master 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(N - 1);
        end else if (granted) begin
            last_q <= idx;
        end
    end

endmodule

// File: rtl/rip_axi_arbiter.sv
// N-master to 1-slave AXI4 interconnect; master index is prepended to outgoing IDs.
module rip_axi_arbiter
    import rip_axi_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    localparam int unsigned MIDX_W = midx_width(NUM_MASTERS),
    localparam int unsigned SID_W  = AXI_ID_WIDTH + MIDX_W,
    localparam int unsigned NM     = NUM_MASTERS,
    localparam int unsigned IW     = AXI_ID_WIDTH,
    localparam int unsigned AW     = AXI_ADDR_WIDTH,
    localparam int unsigned DW     = AXI_DATA_WIDTH,
    localparam int unsigned SW     = AXI_DATA_WIDTH / 8
) (
    input  logic             clk,
    input  logic             sys_rst_n,
    input  logic [NM*IW-1:0] M_AWID,
    input  logic [NM*AW-1:0] M_AWADDR,
    input  logic [NM*8-1:0]  M_AWLEN,
    input  logic [NM*3-1:0]  M_AWSIZE,
    input  logic [NM*2-1:0]  M_AWBURST,
    input  logic [NM-1:0]    M_AWVALID,
    output logic [NM-1:0]    M_AWREADY,
    input  logic [NM*DW-1:0] M_WDATA,
    input  logic [NM*SW-1:0] M_WSTRB,
    input  logic [NM-1:0]    M_WLAST,
    input  logic [NM-1:0]    M_WVALID,
    output logic [NM-1:0]    M_WREADY,
    output logic [NM*IW-1:0] M_BID,
    output logic [NM*2-1:0]  M_BRESP,
    output logic [NM-1:0]    M_BVALID,
    input  logic [NM-1:0]    M_BREADY,
    input  logic [NM*IW-1:0] M_ARID,
    input  logic [NM*AW-1:0] M_ARADDR,
    input  logic [NM*8-1:0]  M_ARLEN,
    input  logic [NM*3-1:0]  M_ARSIZE,
    input  logic [NM*2-1:0]  M_ARBURST,
    input  logic [NM-1:0]    M_ARVALID,
    output logic [NM-1:0]    M_ARREADY,
    output logic [NM*IW-1:0] M_RID,
    output logic [NM*DW-1:0] M_RDATA,
    output logic [NM*2-1:0]  M_RRESP,
    output logic [NM-1:0]    M_RLAST,
    output logic [NM-1:0]    M_RVALID,
    input  logic [NM-1:0]    M_RREADY,
    output logic [SID_W-1:0] AWID,
    output logic [AW-1:0]    AWADDR,
    output logic [7:0]       AWLEN,
    output logic [2:0]       AWSIZE,
    output logic [1:0]       AWBURST,
    output logic             AWLOCK,
    output logic [3:0]       AWCACHE,
    output logic [2:0]       AWPROT,
    output logic [3:0]       AWQOS,
    output logic [3:0]       AWREGION,
    output logic             AWVALID,
    input  logic             AWREADY,
    output logic [DW-1:0]    WDATA,
    output logic [SW-1:0]    WSTRB,
    output logic             WLAST,
    output logic             WVALID,
    input  logic             WREADY,
    input  logic [SID_W-1:0] BID,
    input  logic [1:0]       BRESP,
    input  logic             BVALID,
    output logic             BREADY,
    output logic [SID_W-1:0] ARID,
    output logic [AW-1:0]    ARADDR,
    output logic [7:0]       ARLEN,
    output logic [2:0]       ARSIZE,
    output logic [1:0]       ARBURST,
    output logic             ARLOCK,
    output logic [3:0]       ARCACHE,
    output logic [2:0]       ARPROT,
    output logic [3:0]       ARQOS,
    output logic [3:0]       ARREGION,
    output logic             ARVALID,
    input  logic             ARREADY,
    input  logic [SID_W-1:0] RID,
    input  logic [DW-1:0]    RDATA,
    input  logic [1:0]       RRESP,
    input  logic             RLAST,
    input  logic             RVALID,
    output logic             RREADY
);

    logic              ar_en, ar_take, aw_en, aw_take;
    logic [MIDX_W-1:0] ar_idx, aw_idx, wsel_q, ridx, bidx;
    wstate_e           w_state_q, w_state_d;

    assign {AWLOCK, ARLOCK}     = 2'b00;
    assign {AWCACHE, ARCACHE}   = {CACHE_DEFAULT, CACHE_DEFAULT};
    assign {AWPROT, ARPROT}     = '0;
    assign {AWQOS, ARQOS}       = '0;
    assign {AWREGION, ARREGION} = '0;

    // ---------------- AR: one-entry register, refills in the cycle it drains
    assign ar_en = !ARVALID || ARREADY;

    rip_rr_arbiter #(.N(NM), .IDX_W(MIDX_W)) u_ar_arb (
        .clk     (clk),
        .rst_n   (sys_rst_n),
        .req     (M_ARVALID),
        .en      (ar_en),
        .grant   (M_ARREADY),
        .idx     (ar_idx),
        .granted (ar_take)
    );

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ARVALID <= 1'b0;
            ARID    <= '0;
            ARADDR  <= '0;
            ARLEN   <= '0;
            ARSIZE  <= '0;
            ARBURST <= '0;
        end else if (ar_en) begin
            ARVALID <= ar_take;
            if (ar_take) begin
                ARID    <= {ar_idx, M_ARID[int'(ar_idx)*IW +: IW]};
                ARADDR  <= M_ARADDR[int'(ar_idx)*AW +: AW];
                ARLEN   <= M_ARLEN[int'(ar_idx)*8 +: 8];
                ARSIZE  <= M_ARSIZE[int'(ar_idx)*3 +: 3];
                ARBURST <= M_ARBURST[int'(ar_idx)*2 +: 2];
            end
        end
    end

    // ---------------- AW: grants only while no write burst is in flight
    assign aw_en = (w_state_q == W_IDLE) && (!AWVALID || AWREADY);

    rip_rr_arbiter #(.N(NM), .IDX_W(MIDX_W)) u_aw_arb (
        .clk     (clk),
        .rst_n   (sys_rst_n),
        .req     (M_AWVALID),
        .en      (aw_en),
        .grant   (M_AWREADY),
        .idx     (aw_idx),
        .granted (aw_take)
    );

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            AWVALID <= 1'b0;
            AWID    <= '0;
            AWADDR  <= '0;
            AWLEN   <= '0;
            AWSIZE  <= '0;
            AWBURST <= '0;
            wsel_q  <= '0;
        end else if (aw_take) begin
            AWVALID <= 1'b1;
            AWID    <= {aw_idx, M_AWID[int'(aw_idx)*IW +: IW]};
            AWADDR  <= M_AWADDR[int'(aw_idx)*AW +: AW];
            AWLEN   <= M_AWLEN[int'(aw_idx)*8 +: 8];
            AWSIZE  <= M_AWSIZE[int'(aw_idx)*3 +: 3];
            AWBURST <= M_AWBURST[int'(aw_idx)*2 +: 2];
            wsel_q  <= aw_idx;
        end else if (AWREADY) begin
            AWVALID <= 1'b0;
        end
    end

    // ---------------- Write FSM
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) w_state_q <= W_IDLE;
        else            w_state_q <= w_state_d;
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            W_IDLE:  if (aw_take) w_state_d = W_DATA;
            W_DATA:  if (WVALID && WREADY && WLAST) w_state_d = W_RESP;
            W_RESP:  if (BVALID && BREADY) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // W data may run ahead of the AW register draining.
    always_comb begin
        WDATA    = M_WDATA[int'(wsel_q)*DW +: DW];
        WSTRB    = M_WSTRB[int'(wsel_q)*SW +: SW];
        WLAST    = M_WLAST[wsel_q];
        WVALID   = 1'b0;
        M_WREADY = '0;
        if (w_state_q == W_DATA) begin
            WVALID           = M_WVALID[wsel_q];
            M_WREADY[wsel_q] = WREADY;
        end
    end

    // ---------------- R and B: routed by ID index, unknown indices sunk
    assign ridx    = RID[SID_W-1:IW];
    assign bidx    = BID[SID_W-1:IW];
    assign M_RID   = {NM{RID[IW-1:0]}};
    assign M_RDATA = {NM{RDATA}};
    assign M_RRESP = {NM{RRESP}};
    assign M_RLAST = {NM{RLAST}};
    assign M_BID   = {NM{BID[IW-1:0]}};
    assign M_BRESP = {NM{BRESP}};

    always_comb begin
        M_RVALID = '0;
        RREADY   = 1'b1;
        M_BVALID = '0;
        BREADY   = 1'b1;
        for (int i = 0; i < int'(NM); i++) begin
            if (ridx == MIDX_W'(i)) begin
                M_RVALID[i] = RVALID;
                RREADY      = M_RREADY[i];
            end
            if (bidx == MIDX_W'(i)) begin
                M_BVALID[i] = BVALID;
                BREADY      = M_BREADY[i];
            end
        end
    end

endmodule
